// File: rtl/rgb_stream_packer_pkg.sv
// Shared video definitions: pixel/stream widths, byte-keep constant and the
// packing phase encoding used by the RGB-to-AXI-Stream packer.
package rgb_stream_packer_pkg;

  localparam int PIX_W    = 24;
  localparam int STREAM_W = 32;
  localparam int KEEP_W   = STREAM_W / 8;

  localparam logic [KEEP_W-1:0] KEEP_ALL = 4'hF;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  function automatic phase_t phase_inc(input phase_t p);
    case (p)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/rgb_stream_packer.sv
// Packs four 24-bit RGB pixels into three 32-bit AXI4-Stream words, carrying
// start-of-frame on tuser and end-of-line on tlast through a registered output.
module rgb_stream_packer
  import rgb_stream_packer_pkg::*;
(
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [7:0]          r,
  input  logic [7:0]          g,
  input  logic [7:0]          b,
  input  logic                valid,
  input  logic                sof,
  input  logic                eol,
  output logic                in_stream_ready,
  output logic [STREAM_W-1:0] out_stream_tdata,
  output logic [KEEP_W-1:0]   out_stream_tkeep,
  output logic                out_stream_tlast,
  output logic                out_stream_tuser,
  output logic                out_stream_tvalid,
  input  logic                out_stream_tready
);

  logic [PIX_W-1:0]    pix;
  logic [PIX_W-1:0]    held;
  logic [STREAM_W-1:0] word;
  logic                accept;
  logic                emit;
  logic                sof_pend;
  phase_t              phase;
  phase_t              phase_eff;
  phase_t              phase_nxt;

  assign in_stream_ready  = !out_stream_tvalid || out_stream_tready;
  assign out_stream_tkeep = KEEP_ALL;

  always_comb begin
    pix       = {r, g, b};
    accept    = valid && in_stream_ready;
    phase_eff = sof ? PH0 : phase;
    word      = '0;
    case (phase_eff)
      PH1:     word = {pix[7:0],  held};
      PH2:     word = {pix[15:0], held[23:8]};
      PH3:     word = {pix,       held[23:16]};
      default: word = '0;
    endcase
    // An eol before the group is complete drops the partial data silently.
    emit      = accept && ((phase_eff == PH3) || ((phase_eff != PH0) && !eol));
    phase_nxt = eol ? PH0 : phase_inc(phase_eff);
  end

  // Stage boundary: pixel accept -> phase/hold state and registered output word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase             <= PH0;
      held              <= '0;
      sof_pend          <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      if (accept) begin
        phase <= phase_nxt;
        held  <= pix;
        if (sof)
          sof_pend <= 1'b1;
        else if (emit)
          sof_pend <= 1'b0;
      end
      if (emit) begin
        out_stream_tvalid <= 1'b1;
        out_stream_tdata  <= word;
        out_stream_tlast  <= eol;
        out_stream_tuser  <= sof_pend;
      end else if (out_stream_tready) begin
        out_stream_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Scoreboard bench for rgb_stream_packer: a group-level reference model predicts
// each output word, a monitor pops and compares on every handshake.
module tb_rgb_stream_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
  logic        out_stream_tready;

  always #5 aclk = ~aclk;

  rgb_stream_packer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        u;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    out_stream_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      case (rdy_mode)
        0:       out_stream_tready = 1'b1;
        1:       out_stream_tready = ($urandom_range(0, 3) != 0);
        default: out_stream_tready = 1'b0;
      endcase
    end
  end

  // Reference model: pixels of a group concatenated little-end first; the
  // n-th word of a group is simply bits [32n+31:32n] of that concatenation.
  logic [23:0] grp[$];
  logic [95:0] m_cat;
  logic        m_sof = 1'b0;
  word_t       m_w;
  int          m_n;

  always @(negedge aclk) begin
    if (!aresetn) begin
      grp.delete();
      exp_q.delete();
      m_sof = 1'b0;
    end else if (valid && in_stream_ready) begin
      if (sof) begin
        grp.delete();
        m_sof = 1'b1;
      end
      grp.push_back({r, g, b});
      if (eol && grp.size() < 4) begin
        grp.delete();
      end else if (grp.size() >= 2) begin
        m_cat = '0;
        for (int i = 0; i < grp.size(); i++) m_cat[24*i +: 24] = grp[i];
        m_n   = grp.size() - 2;
        m_w.d = m_cat[32*m_n +: 32];
        m_w.l = eol;
        m_w.u = m_sof;
        m_sof = 1'b0;
        exp_q.push_back(m_w);
        if (grp.size() == 4) grp.delete();
      end
    end
  end

  // Monitor: compares every handshaken word and checks hold-under-stall.
  logic [31:0] last_d;
  logic        stalled = 1'b0;
  word_t       got, want;

  always @(negedge aclk) begin
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_stream_tvalid)
        check("tdata_stable", out_stream_tdata, last_d);
      if (out_stream_tvalid && !out_stream_tready)
        check("in_ready_low_on_stall", in_stream_ready, 1'b0);
      if (out_stream_tvalid && out_stream_tready) begin
        got.d = out_stream_tdata;
        got.l = out_stream_tlast;
        got.u = out_stream_tuser;
        obs_q.push_back(got);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got 0x%0h, expected no word at %0t", out_stream_tdata, $time);
        end else begin
          want = exp_q.pop_front();
          check("tdata", out_stream_tdata, want.d);
          check("tlast", out_stream_tlast, want.l);
          check("tuser", out_stream_tuser, want.u);
          check("tkeep", out_stream_tkeep, 4'hF);
        end
      end
      stalled = out_stream_tvalid && !out_stream_tready;
      last_d  = out_stream_tdata;
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic send_pix(input logic [23:0] p, input logic s, input logic e);
    int t;
    {r, g, b} = p;
    sof   = s;
    eol   = e;
    valid = 1'b1;
    t     = 0;
    @(negedge aclk);
    while (!in_stream_ready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!in_stream_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0, expected ready=1 within 200 cycles");
    end
    @(posedge aclk);
    #1;
    valid = 1'b0;
    sof   = 1'b0;
    eol   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_stream_tvalid) && t < 500) begin
      @(posedge aclk);
      t++;
    end
    #1;
    if (exp_q.size() != 0 || out_stream_tvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  int          nlast;
  int          pos;
  logic [23:0] px[4];
  logic [23:0] ps, pq;
  logic        rs, re;

  initial begin
    aresetn = 1'b0;
    valid   = 1'b0;
    sof     = 1'b0;
    eol     = 1'b0;
    {r, g, b} = 24'h0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", out_stream_tvalid, 1'b0);
    check("rst_ready", in_stream_ready, 1'b1);
    check("rst_tdata", out_stream_tdata, 32'h0);
    check("rst_tlast", out_stream_tlast, 1'b0);
    check("rst_tuser", out_stream_tuser, 1'b0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(2);

    // Basic group of four pixels
    obs_q.delete();
    send_pix(24'h112233, 1'b0, 1'b0);
    check("no_word_first_pixel", out_stream_tvalid, 1'b0);
    send_pix(24'h445566, 1'b0, 1'b0);
    send_pix(24'h778899, 1'b0, 1'b0);
    send_pix(24'hAABBCC, 1'b0, 1'b0);
    drain();
    check("basic_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("basic_w0", obs_q[0].d, 32'h66112233);
      check("basic_w1", obs_q[1].d, 32'h88994455);
      check("basic_w2", obs_q[2].d, 32'hAABBCC77);
      check("basic_tuser0", obs_q[0].u, 1'b0);
    end

    // Same stream with sof on the first pixel
    obs_q.delete();
    send_pix(24'h112233, 1'b1, 1'b0);
    send_pix(24'h445566, 1'b0, 1'b0);
    send_pix(24'h778899, 1'b0, 1'b0);
    send_pix(24'hAABBCC, 1'b0, 1'b0);
    drain();
    check("sof_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("sof_w0_d", obs_q[0].d, 32'h66112233);
      check("sof_w0_user", obs_q[0].u, 1'b1);
      check("sof_w1_user", obs_q[1].u, 1'b0);
      check("sof_w2_user", obs_q[2].u, 1'b0);
    end

    // Full 640-pixel line under random backpressure
    rdy_mode = 1;
    obs_q.delete();
    for (int i = 0; i < 640; i++)
      send_pix(24'($urandom), (i == 0), (i == 639));
    drain();
    check("line_words", obs_q.size(), 480);
    nlast = 0;
    foreach (obs_q[i]) if (obs_q[i].l) nlast++;
    check("line_tlast_count", nlast, 1);
    if (obs_q.size() == 480) check("line_tlast_on_479", obs_q[479].l, 1'b1);
    rdy_mode = 0;
    idle(2);

    // Five-cycle downstream stall mid-group
    obs_q.delete();
    send_pix(24'h010203, 1'b0, 1'b0);
    send_pix(24'h040506, 1'b0, 1'b0);
    rdy_mode = 2;
    repeat (5) begin
      @(negedge aclk);
      check("stall_in_ready", in_stream_ready, 1'b0);
      check("stall_tvalid", out_stream_tvalid, 1'b1);
    end
    @(posedge aclk);
    #1;
    rdy_mode = 0;
    send_pix(24'h070809, 1'b0, 1'b0);
    send_pix(24'h0A0B0C, 1'b0, 1'b0);
    drain();
    check("stall_words", obs_q.size(), 3);

    // sof arriving at phase 2 drops the partial group
    obs_q.delete();
    ps = 24'hC0FFEE;
    pq = 24'h5A6B7C;
    send_pix(24'h111111, 1'b0, 1'b0);
    send_pix(24'h222222, 1'b0, 1'b0);
    send_pix(ps, 1'b1, 1'b0);
    send_pix(pq, 1'b0, 1'b0);
    send_pix(24'h333333, 1'b0, 1'b0);
    send_pix(24'h444444, 1'b0, 1'b1);
    drain();
    check("sofmid_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("sofmid_word", obs_q[1].d, {pq[7:0], ps});
      check("sofmid_user", obs_q[1].u, 1'b1);
      check("sofmid_last", obs_q[3].l, 1'b1);
    end

    // Reset in the middle of a group with a word pending
    send_pix(24'hDEAD01, 1'b0, 1'b0);
    send_pix(24'hDEAD02, 1'b0, 1'b0);
    rdy_mode = 2;
    aresetn  = 1'b0;
    @(posedge aclk);
    #1;
    aresetn  = 1'b1;
    rdy_mode = 0;
    @(negedge aclk);
    check("rst_mid_tvalid", out_stream_tvalid, 1'b0);
    @(posedge aclk);
    #1;
    obs_q.delete();
    for (int i = 0; i < 4; i++) px[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) send_pix(px[i], 1'b0, 1'b0);
    drain();
    check("rst_mid_words", obs_q.size(), 3);
    if (obs_q.size() == 3) check("rst_mid_w0", obs_q[0].d, {px[1][7:0], px[0]});

    // Randomized traffic: gaps, backpressure, sof/eol at arbitrary points
    rdy_mode = 1;
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 63) == 0);
      if (rs) pos = 0;
      re = ((pos % 4 == 3) && $urandom_range(0, 7) == 0) || ($urandom_range(0, 99) == 0);
      send_pix(24'($urandom), rs, re);
      pos = re ? 0 : pos + 1;
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rdy_mode = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no completion, expected finish before 5ms");
    $fatal(1, "timeout");
  end

endmodule
